// File: rtl/data_sram_responder.sv
// Data-memory responder: byte-lane writes into a word array, fixed-latency read
// responses, and an output FIFO whose occupancy limits request acceptance.
module data_sram_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int DEPTH = LATENCY + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int WORDS = 1 << ADDR_W;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lane_en
    );
        logic [31:0] result;
        for (int k = 0; k < 4; k++) begin
            result[8*k +: 8] = lane_en[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
        end
        return result;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    logic [31:0]       mem_r [WORDS];
    logic [CNT_W-1:0]  occ_r;
    logic              req_ready_s;
    logic              accept_s;
    logic              pop_s;
    logic              is_write_s;
    logic              oor_s;
    logic [ADDR_W-1:0] idx_s;
    logic              unused_addr_s;

    logic              in_valid_s;
    logic              in_err_s;
    logic [31:0]       in_rdata_s;
    logic              push_valid_s;
    logic              push_err_s;
    logic [31:0]       push_rdata_s;

    logic [31:0]       fifo_rdata_r [DEPTH];
    logic              fifo_err_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  fifo_cnt_r;
    logic              resp_valid_s;

    assign idx_s         = req_addr[ADDR_W+1:2];
    assign oor_s         = |req_addr[31:ADDR_W+2];
    assign is_write_s    = |req_wen;
    assign unused_addr_s = ^req_addr[1:0];

    assign req_ready_s  = !rst && (occ_r < CNT_W'(DEPTH));
    assign accept_s     = req_valid && req_ready_s;
    assign resp_valid_s = (fifo_cnt_r != '0);
    assign pop_s        = resp_valid_s && resp_ready;

    // Response content captured at the accept edge; the array read sees all earlier writes.
    always_comb begin
        in_valid_s = accept_s;
        in_err_s   = 1'b0;
        in_rdata_s = 32'h0000_0000;
        if (accept_s && oor_s) begin
            in_err_s = 1'b1;
        end else if (accept_s && !is_write_s) begin
            in_rdata_s = mem_r[idx_s];
        end else begin
            in_err_s   = 1'b0;
            in_rdata_s = 32'h0000_0000;
        end
    end

    // Byte-lane write into the word array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && is_write_s && !oor_s) begin
            mem_r[idx_s] <= merge_lanes(mem_r[idx_s], req_wdata, req_wen);
        end
    end

    // The accept edge counts as the first latency stage, so LATENCY-1 registers follow it.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_valid_s = in_valid_s;
            assign push_err_s   = in_err_s;
            assign push_rdata_s = in_rdata_s;
        end else begin : g_pipe
            logic        pipe_valid_r [LATENCY-1];
            logic        pipe_err_r   [LATENCY-1];
            logic [31:0] pipe_rdata_r [LATENCY-1];

            // Shift pipeline carrying valid/err/rdata toward the output FIFO.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        pipe_valid_r[i] <= 1'b0;
                        pipe_err_r[i]   <= 1'b0;
                        pipe_rdata_r[i] <= 32'h0000_0000;
                    end
                end else begin
                    pipe_valid_r[0] <= in_valid_s;
                    pipe_err_r[0]   <= in_err_s;
                    pipe_rdata_r[0] <= in_rdata_s;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe_valid_r[i] <= pipe_valid_r[i-1];
                        pipe_err_r[i]   <= pipe_err_r[i-1];
                        pipe_rdata_r[i] <= pipe_rdata_r[i-1];
                    end
                end
            end

            assign push_valid_s = pipe_valid_r[LATENCY-2];
            assign push_err_s   = pipe_err_r[LATENCY-2];
            assign push_rdata_s = pipe_rdata_r[LATENCY-2];
        end
    endgenerate

    // FIFO storage; stale entries are harmless because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_valid_s) begin
            fifo_rdata_r[wr_ptr_r] <= push_rdata_s;
            fifo_err_r[wr_ptr_r]   <= push_err_s;
        end
    end

    // FIFO pointers and entry count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (push_valid_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_valid_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Requests accepted but not yet popped; bounding this by the FIFO depth prevents overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r <= '0;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   occ_r <= occ_r + CNT_W'(1);
                2'b01:   occ_r <= occ_r - CNT_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign resp_valid = resp_valid_s;
    assign resp_rdata = resp_valid_s ? fifo_rdata_r[rd_ptr_r] : 32'h0000_0000;
    assign resp_err   = resp_valid_s ? fifo_err_r[rd_ptr_r] : 1'b0;
    assign busy       = (occ_r != '0);

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder (ADDR_W=10, LATENCY=2): a cycle table for
// reset/write/read/byte-lane/out-of-range, then back-pressure and mid-flight reset sequences.
module tb_data_sram_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int checks;
    int failures;

    data_sram_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req_valid;
        logic [3:0]  req_wen;
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic        resp_ready;
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_busy;
    } vec_t;

    localparam int NV = 13;
    vec_t tv [NV];

    task automatic check_eq(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic issue(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        int waited;
        waited = 0;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        while (!req_ready && waited < 20) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check_eq("issue_accepted", {31'd0, req_ready}, 32'd1);
        next_cycle();
        req_valid = 1'b0;
        req_wen   = 4'h0;
    endtask

    logic [31:0] bp_data [5];
    int n_acc;
    int n_resp;
    int seen;

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 4'h0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;

        //            rst   rv    wen    addr          wdata         rr    ready valid rdata         err   busy
        tv[0]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 1'b1, 4'h4, 32'h0000_0042, 32'hAABB_CCDD, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0040, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b1};
        tv[7]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0000, 32'h5A5A_A5A5, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        tv[8]  = '{1'b0, 1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h12BB_5678, 1'b0, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        tv[10] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1};
        tv[11] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 32'h5A5A_A5A5, 1'b0, 1'b1};
        tv[12] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};

        next_cycle();

        for (int i = 0; i < NV; i++) begin
            rst        = tv[i].rst;
            req_valid  = tv[i].req_valid;
            req_wen    = tv[i].req_wen;
            req_addr   = tv[i].req_addr;
            req_wdata  = tv[i].req_wdata;
            resp_ready = tv[i].resp_ready;
            #1;
            check_eq($sformatf("v%0d_req_ready", i),  {31'd0, req_ready},  {31'd0, tv[i].exp_ready});
            check_eq($sformatf("v%0d_resp_valid", i), {31'd0, resp_valid}, {31'd0, tv[i].exp_valid});
            check_eq($sformatf("v%0d_resp_rdata", i), resp_rdata,          tv[i].exp_rdata);
            check_eq($sformatf("v%0d_resp_err", i),   {31'd0, resp_err},   {31'd0, tv[i].exp_err});
            check_eq($sformatf("v%0d_busy", i),       {31'd0, busy},       {31'd0, tv[i].exp_busy});
            next_cycle();
        end

        // Back-pressure: preload five words, then read them with resp_ready low.
        for (int i = 0; i < 5; i++) begin
            bp_data[i] = 32'h1100_0000 * (i + 1) + 32'h0000_0100 * i + 32'h0000_0007;
            issue(4'hF, 32'h4 * i, bp_data[i]);
        end
        for (int i = 0; i < 6; i++) next_cycle();
        check_eq("bp_idle_busy", {31'd0, busy}, 32'd0);

        resp_ready = 1'b0;
        n_acc  = 0;
        n_resp = 0;
        for (int c = 0; c < 60 && n_resp < 5; c++) begin
            if (c == 5) resp_ready = 1'b1;
            req_valid = (n_acc < 5);
            req_wen   = 4'h0;
            req_addr  = 32'h4 * n_acc;
            #1;
            if (c == 4) begin
                check_eq("bp_ready_low_when_full", {31'd0, req_ready}, 32'd0);
                check_eq("bp_accepted_before_pop", n_acc, 32'd3);
            end
            if (c == 5) check_eq("bp_ready_low_at_first_pop", {31'd0, req_ready}, 32'd0);
            if (c == 6) check_eq("bp_ready_after_first_pop", {31'd0, req_ready}, 32'd1);
            if (req_valid && req_ready) n_acc++;
            if (resp_valid && resp_ready) begin
                check_eq($sformatf("bp_rdata_%0d", n_resp), resp_rdata, bp_data[n_resp]);
                check_eq($sformatf("bp_err_%0d", n_resp), {31'd0, resp_err}, 32'd0);
                n_resp++;
            end
            next_cycle();
        end
        req_valid = 1'b0;
        check_eq("bp_total_accepted", n_acc, 32'd5);
        check_eq("bp_total_responses", n_resp, 32'd5);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid) seen++;
            next_cycle();
        end
        check_eq("bp_no_duplicate", seen, 32'd0);

        // Reset while three requests are in flight, one of them a write.
        resp_ready = 1'b0;
        issue(4'h0, 32'h0000_0004, 32'h0);
        issue(4'hF, 32'h0000_0080, 32'hCAFE_F00D);
        issue(4'h0, 32'h0000_0008, 32'h0);
        check_eq("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        req_valid = 1'b1;
        #1;
        check_eq("mid_ready_in_rst", {31'd0, req_ready}, 32'd0);
        next_cycle();
        rst = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (resp_valid || busy) seen++;
            next_cycle();
        end
        check_eq("mid_no_resp_after_rst", seen, 32'd0);

        issue(4'h0, 32'h0000_0080, 32'h0);
        seen = 0;
        for (int c = 0; c < 10 && !resp_valid; c++) begin
            next_cycle();
            seen++;
        end
        check_eq("mid_read_valid", {31'd0, resp_valid}, 32'd1);
        check_eq("mid_read_rdata", resp_rdata, 32'hCAFE_F00D);
        check_eq("mid_read_latency", seen, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
